// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU datapath and a DMA/debug requester.
// The CPU has priority, with a bounded run before DMA gets short priority bursts.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int CPU_RUN   = 4,
    parameter int DMA_BURST = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int RW = $clog2(CPU_RUN + 1);
    localparam int BW = $clog2(DMA_BURST + 1);

    typedef enum logic {P_CPU, P_DMA} mode_t;

    mode_t         mode_q, mode_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          rsel_q, rsel_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mode_d      = mode_q;
        run_cnt_d   = run_cnt_q;
        burst_cnt_d = burst_cnt_q;
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        case (mode_q)
            P_CPU: begin
                if (cpu_req) begin
                    cpu_gnt = 1'b1;
                    if (dma_req) begin
                        // The grant that completes the CPU run hands priority to DMA.
                        if (run_cnt_q >= RW'(CPU_RUN - 1)) begin
                            mode_d      = P_DMA;
                            run_cnt_d   = '0;
                            burst_cnt_d = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + RW'(1);
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end else if (dma_req) begin
                    dma_gnt   = 1'b1;
                    run_cnt_d = '0;
                end
            end
            P_DMA: begin
                if (dma_req) begin
                    dma_gnt = 1'b1;
                    if (burst_cnt_q >= BW'(DMA_BURST - 1)) begin
                        mode_d      = P_CPU;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end else begin
                    // DMA went away mid-burst: the CPU may take this very cycle.
                    mode_d      = P_CPU;
                    burst_cnt_d = '0;
                    run_cnt_d   = '0;
                    cpu_gnt     = cpu_req;
                end
            end
            default: mode_d = P_CPU;
        endcase
    end

    always_comb begin
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    always_comb begin
        rvalid_d = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        rsel_d   = rsel_q;
        if (cpu_gnt || dma_gnt) begin
            rsel_d = dma_gnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= P_CPU;
            run_cnt_q   <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            rsel_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            run_cnt_q   <= run_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
            rsel_q      <= rsel_d;
        end
    end

    // Read data follows the registered selector of the previous read grant.
    assign cpu_rvalid = rvalid_q & ~rsel_q;
    assign dma_rvalid = rvalid_q & rsel_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model on the mem_* port.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0] cpu_rdata, dma_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .CPU_RUN(4), .DMA_BURST(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_rdata (dma_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".cpu_gnt"}, cpu_gnt, 0);
        check({tag, ".dma_gnt"}, dma_gnt, 0);
        check({tag, ".mem_en"}, mem_en, 0);
        check({tag, ".mem_we"}, mem_we, 0);
        check({tag, ".mem_addr"}, mem_addr, 0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
    endtask

    // Requests are held by the caller; seq holds one 'C' or 'D' per expected grant.
    task automatic expect_grants(input string tag, input string seq);
        for (int i = 0; i < seq.len(); i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d].cpu_gnt", tag, i), cpu_gnt, (seq[i] == "C") ? 1 : 0);
            check($sformatf("%s[%0d].dma_gnt", tag, i), dma_gnt, (seq[i] == "D") ? 1 : 0);
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'h3C;
        mem_rdata  = 8'h00;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

        // 1: reset state and idle after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.cpu_rvalid", cpu_rvalid, 0);
        check("rst.dma_rvalid", dma_rvalid, 0);
        check_idle("rst");
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        check_idle("idle");
        check("idle.cpu_rvalid", cpu_rvalid, 0);

        // 2: CPU alone reads 0x10
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        check("t2.cpu_gnt", cpu_gnt, 1);
        check("t2.dma_gnt", dma_gnt, 0);
        check("t2.mem_en", mem_en, 1);
        check("t2.mem_we", mem_we, 0);
        check("t2.mem_addr", mem_addr, 8'h10);
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        check("t2.cpu_rvalid", cpu_rvalid, 1);
        check("t2.cpu_rdata", cpu_rdata, 8'h5A);
        check("t2.dma_rvalid", dma_rvalid, 0);
        check("t2.dma_rdata", dma_rdata, 0);
        next_cycle();
        @(negedge clk);
        check("t2.rvalid_one_cycle", cpu_rvalid, 0);

        // 3: both reading continuously, CCCCDD repeating, rvalid routed by previous grant
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        dma_req = 1; dma_we = 0; dma_addr = 8'h11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t3[%0d].cpu_gnt", i), cpu_gnt, ((i % 6) < 4) ? 1 : 0);
            check($sformatf("t3[%0d].dma_gnt", i), dma_gnt, ((i % 6) >= 4) ? 1 : 0);
            if (i == 4) begin
                check("t3.c2d.cpu_rvalid", cpu_rvalid, 1);
                check("t3.c2d.cpu_rdata", cpu_rdata, 8'h5A);
                check("t3.c2d.dma_rvalid", dma_rvalid, 0);
            end
            if (i == 6) begin
                check("t3.d2c.dma_rvalid", dma_rvalid, 1);
                check("t3.d2c.dma_rdata", dma_rdata, 8'h3C);
                check("t3.d2c.cpu_rvalid", cpu_rvalid, 0);
                check("t3.d2c.cpu_rdata", cpu_rdata, 0);
            end
            next_cycle();
        end
        cpu_req = 0; dma_req = 0;
        next_cycle();

        // 4: DMA alone writes 0xA5 to 0x20, then CPU reads it back
        dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'hA5;
        @(negedge clk);
        check("t4.dma_gnt", dma_gnt, 1);
        check("t4.cpu_gnt", cpu_gnt, 0);
        check("t4.mem_en", mem_en, 1);
        check("t4.mem_we", mem_we, 1);
        check("t4.mem_addr", mem_addr, 8'h20);
        check("t4.mem_wdata", mem_wdata, 8'hA5);
        next_cycle();
        dma_req = 0; dma_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        @(negedge clk);
        check("t4.write_no_rvalid", dma_rvalid, 0);
        check("t4.rd.cpu_gnt", cpu_gnt, 1);
        check("t4.rd.mem_addr", mem_addr, 8'h20);
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        check("t4.rd.cpu_rvalid", cpu_rvalid, 1);
        check("t4.rd.cpu_rdata", cpu_rdata, 8'hA5);
        next_cycle();

        // 5: DMA drops after one priority grant while CPU waits
        cpu_req = 1; cpu_addr = 8'h10;
        dma_req = 1; dma_addr = 8'h11;
        expect_grants("t5.pre", "CCCCD");
        dma_req = 0;
        @(negedge clk);
        check("t5.drop.cpu_gnt", cpu_gnt, 1);
        check("t5.drop.dma_gnt", dma_gnt, 0);
        next_cycle();
        dma_req = 1;
        expect_grants("t5.post", "CCCCDDC");
        cpu_req = 0; dma_req = 0;
        next_cycle();

        // 6: reset right after a CPU read grant, with the run counter part-way
        cpu_req = 1; cpu_addr = 8'h10;
        dma_req = 1; dma_addr = 8'h11;
        expect_grants("t6.pre", "CC");
        @(negedge clk);
        check("t6.cpu_gnt", cpu_gnt, 1);
        reset = 1'b1;
        cpu_req = 0; dma_req = 0;
        @(negedge clk);
        check("t6.cpu_rvalid", cpu_rvalid, 0);
        check("t6.dma_rvalid", dma_rvalid, 0);
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        check_idle("t6.idle");
        next_cycle();
        cpu_req = 1; dma_req = 1;
        expect_grants("t6.post", "CCCCD");
        cpu_req = 0; dma_req = 0;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
